fft_frame_rx: RTL and testbench

//  Receive end of the sample-enable produced by the upstream count-threshold / delay-chain block.

---
 rtl/fft_frame_rx.sv | 69 ++++++
 tb/tb_fft_frame_rx.sv | 106 ++++++++++
 2 files changed

// File: rtl/fft_frame_rx.sv
// fft_frame_rx: frames a level sample-enable plus data bus into N-point FFT input with index, sop/eop, frame count, drop-out error.
//  clk, rst (sync, active-low) | en_in, din in | dout, dvalid, idx, sop, eop, frames, err_drop out (all registered)
module fft_frame_rx #(
  parameter int N  = 128,
  parameter int DW = 16,
  parameter int IW = 7,
  parameter int FW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en_in,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic          dvalid,
  output logic [IW-1:0] idx,
  output logic          sop,
  output logic          eop,
  output logic [FW-1:0] frames,
  output logic          err_drop
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t        state_q, state_d;
  logic [IW-1:0] cnt_q, cnt_d, idx_q, idx_d;
  logic [DW-1:0] dout_q, dout_d;
  logic [FW-1:0] frames_q, frames_d;
  logic          dvalid_q, dvalid_d, sop_q, sop_d, eop_q, eop_d, err_q, err_d;
  // cnt wraps to 0 after N-1 on its own because IW == log2(N)
  always_comb begin
    state_d  = en_in ? RUN : IDLE;
    cnt_d    = en_in ? cnt_q + IW'(1) : '0;
    dout_d   = en_in ? din : dout_q;
    idx_d    = en_in ? cnt_q : idx_q;
    dvalid_d = en_in;
    sop_d    = en_in && cnt_q == '0;
    eop_d    = en_in && cnt_q == IW'(N - 1);
    frames_d = frames_q + FW'(eop_d);
    err_d    = !en_in && state_q == RUN && cnt_q != '0;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      dout_q   <= '0;
      idx_q    <= '0;
      dvalid_q <= 1'b0;
      sop_q    <= 1'b0;
      eop_q    <= 1'b0;
      frames_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dout_q   <= dout_d;
      idx_q    <= idx_d;
      dvalid_q <= dvalid_d;
      sop_q    <= sop_d;
      eop_q    <= eop_d;
      frames_q <= frames_d;
      err_q    <= err_d;
    end
  end
  assign dout     = dout_q;
  assign dvalid   = dvalid_q;
  assign idx      = idx_q;
  assign sop      = sop_q;
  assign eop      = eop_q;
  assign frames   = frames_q;
  assign err_drop = err_q;
endmodule

// File: tb/tb_fft_frame_rx.sv
// tb_fft_frame_rx: directed vector bench for fft_frame_rx (main N=128 build plus a small N=4, FW=2 build for frame-counter wrap).
module tb_fft_frame_rx;
  localparam int OW = 43;
  logic        clk = 1'b0, rst = 1'b0, en_in = 1'b0;
  logic [15:0] din = '0;
  logic [15:0] dout, frames, dout2;
  logic [6:0]  idx;
  logic [1:0]  idx2, frames2;
  logic        dvalid, sop, eop, err_drop, dvalid2, sop2, eop2, err2;
  int          checks = 0, errors = 0;
  always #5 clk = ~clk;
  fft_frame_rx u_dut (.clk(clk), .rst(rst), .en_in(en_in), .din(din), .dout(dout), .dvalid(dvalid),
    .idx(idx), .sop(sop), .eop(eop), .frames(frames), .err_drop(err_drop));
  fft_frame_rx #(.N(4), .DW(16), .IW(2), .FW(2)) u_small (.clk(clk), .rst(rst), .en_in(en_in), .din(din),
    .dout(dout2), .dvalid(dvalid2), .idx(idx2), .sop(sop2), .eop(eop2), .frames(frames2), .err_drop(err2));
  typedef struct {
    logic r; logic e; logic [15:0] d;
    logic dv; logic [6:0] ix; logic s; logic eo; logic er; logic [15:0] fr; logic [15:0] dou;
  } vec_t;
  vec_t tv[9];
  function automatic logic [OW-1:0] pk(logic dv, logic [6:0] ix, logic s, logic eo, logic er,
                                       logic [15:0] fr, logic [15:0] dou);
    return {dv, ix, s, eo, er, fr, dou};
  endfunction
  task automatic chk(input string nm, input int n, input logic [OW-1:0] got, input logic [OW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %h expected %h (dv,idx,sop,eop,err,frames,dout)", nm, n, got, exp);
    end
  endtask
  task automatic cyc(input logic r, input logic e, input logic [15:0] d);
    rst = r; en_in = e; din = d;
    @(posedge clk);
    #1;
  endtask
  function automatic logic [OW-1:0] act();
    return {dvalid, idx, sop, eop, err_drop, frames, dout};
  endfunction
  initial begin
    // reset held with en_in=1, then a 2-sample partial frame, then a 1-sample partial frame
    tv[0] = '{1'b0, 1'b1, 16'h1234, 1'b0, 7'd0, 1'b0, 1'b0, 1'b0, 16'd0, 16'h0000};
    tv[1] = '{1'b0, 1'b1, 16'h1234, 1'b0, 7'd0, 1'b0, 1'b0, 1'b0, 16'd0, 16'h0000};
    tv[2] = '{1'b0, 1'b1, 16'h1234, 1'b0, 7'd0, 1'b0, 1'b0, 1'b0, 16'd0, 16'h0000};
    tv[3] = '{1'b1, 1'b1, 16'hAAAA, 1'b1, 7'd0, 1'b1, 1'b0, 1'b0, 16'd0, 16'hAAAA};
    tv[4] = '{1'b1, 1'b1, 16'hBBBB, 1'b1, 7'd1, 1'b0, 1'b0, 1'b0, 16'd0, 16'hBBBB};
    tv[5] = '{1'b1, 1'b0, 16'h5555, 1'b0, 7'd1, 1'b0, 1'b0, 1'b1, 16'd0, 16'hBBBB};
    tv[6] = '{1'b1, 1'b1, 16'hCCCC, 1'b1, 7'd0, 1'b1, 1'b0, 1'b0, 16'd0, 16'hCCCC};
    tv[7] = '{1'b1, 1'b0, 16'h7777, 1'b0, 7'd0, 1'b0, 1'b0, 1'b1, 16'd0, 16'hCCCC};
    tv[8] = '{1'b1, 1'b0, 16'h7777, 1'b0, 7'd0, 1'b0, 1'b0, 1'b0, 16'd0, 16'hCCCC};
    for (int i = 0; i < 9; i++) begin
      cyc(tv[i].r, tv[i].e, tv[i].d);
      chk("table", i, act(), pk(tv[i].dv, tv[i].ix, tv[i].s, tv[i].eo, tv[i].er, tv[i].fr, tv[i].dou));
    end
    // single full frame from IDLE, then a clean stop
    cyc(1'b0, 1'b0, 16'h0);
    for (int i = 0; i < 128; i++) begin
      cyc(1'b1, 1'b1, 16'(i));
      chk("frame1", i, act(), pk(1'b1, 7'(i), i == 0, i == 127, 1'b0, 16'(i == 127), 16'(i)));
    end
    cyc(1'b1, 1'b0, 16'hFFFF);
    chk("frame1_stop", 0, act(), pk(1'b0, 7'd127, 1'b0, 1'b0, 1'b0, 16'd1, 16'd127));
    // three back-to-back frames
    cyc(1'b0, 1'b0, 16'h0);
    for (int i = 0; i < 384; i++) begin
      cyc(1'b1, 1'b1, 16'(i + 16'h100));
      chk("b2b", i, act(), pk(1'b1, 7'(i % 128), i % 128 == 0, i % 128 == 127, 1'b0,
                              16'(i / 128 + (i % 128 == 127 ? 1 : 0)), 16'(i + 16'h100)));
    end
    cyc(1'b1, 1'b0, 16'h0);
    chk("b2b_stop", 0, act(), pk(1'b0, 7'd127, 1'b0, 1'b0, 1'b0, 16'd3, 16'(383 + 16'h100)));
    // drop-out after 50 samples, then a full frame
    cyc(1'b0, 1'b0, 16'h0);
    for (int i = 0; i < 50; i++) begin
      cyc(1'b1, 1'b1, 16'(i));
      chk("drop_a", i, act(), pk(1'b1, 7'(i), i == 0, 1'b0, 1'b0, 16'd0, 16'(i)));
    end
    cyc(1'b1, 1'b0, 16'hDEAD);
    chk("drop_err", 0, act(), pk(1'b0, 7'd49, 1'b0, 1'b0, 1'b1, 16'd0, 16'd49));
    for (int i = 0; i < 128; i++) begin
      cyc(1'b1, 1'b1, 16'(i + 16'h200));
      chk("drop_b", i, act(), pk(1'b1, 7'(i), i == 0, i == 127, 1'b0, 16'(i == 127), 16'(i + 16'h200)));
    end
    // reset mid-frame at idx 60 drops the partial frame silently
    cyc(1'b0, 1'b0, 16'h0);
    for (int i = 0; i <= 60; i++) begin
      cyc(1'b1, 1'b1, 16'(i));
      chk("rst_a", i, act(), pk(1'b1, 7'(i), i == 0, 1'b0, 1'b0, 16'd0, 16'(i)));
    end
    cyc(1'b0, 1'b1, 16'h9999);
    chk("rst_mid", 0, act(), pk(1'b0, 7'd0, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0));
    for (int i = 0; i < 128; i++) begin
      cyc(1'b1, 1'b1, 16'(i + 16'h300));
      chk("rst_b", i, act(), pk(1'b1, 7'(i), i == 0, i == 127, 1'b0, 16'(i == 127), 16'(i + 16'h300)));
    end
    // frame counter wrap on the N=4, FW=2 build: frames 1,2,3 then 0 with eop still high
    cyc(1'b0, 1'b0, 16'h0);
    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, 1'b1, 16'(i));
      chk("wrap", i, OW'({dvalid2, idx2, sop2, eop2, err2, frames2}),
          OW'({1'b1, 2'(i % 4), i % 4 == 0, i % 4 == 3, 1'b0, 2'((i + 1) / 4)}));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
